mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Single owner of the byte-wide RAM/IO bus.
- Serves two requesters: instruction-fetch words from the instruction cache, and 1/2/4-byte loads and stores from the load/store buffer.
- Each granted request becomes a sequence of byte cycles, little-endian, with the 1-cycle read latency handled internally.
- Handles the pipeline flush, the global pause and UART back-pressure; an anti-starvation counter protects instruction fetch.

Parameters:
- FETCH_BYTES, 4, bytes per instruction-fetch transaction.
- STARVE_LIMIT, 4, consecutive lost arbitrations after which the instruction cache wins a tie.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset, synchronous, active-low.
- rdy_in  in  1  global ready; low pauses the block.
- clear  in  1  pipeline flush, active-high, synchronous.
- if_req  in  1  fetch request, level, held until if_done.
- if_addr  in  32  fetch byte address.
- if_done  out  1  one-cycle fetch completion pulse.
- if_data  out  32  fetched word, valid while if_done is high.
- ls_req  in  1  load/store request, level, held until ls_done.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  32  data byte address.
- ls_len  in  3  byte count; only 1, 2 or 4 is legal.
- ls_wdata  in  32  store data, byte 0 = bits 7:0.
- ls_done  out  1  one-cycle completion pulse.
- ls_rdata  out  32  load data, zero-extended, valid while ls_done is high.
- mem_din  in  8  RAM read byte.
- mem_dout  out  8  RAM write byte.
- mem_a  out  32  RAM byte address.
- mem_wr  out  1  1 = write.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset (rst_in low at clock edge):
  - state IDLE; byte counter 0; starve counter 0.
  - All outputs 0: mem_wr, mem_a, mem_dout, if_done, ls_done, if_data, ls_rdata.
  - Reset mid-transaction abandons the transaction; no done pulse is produced.
- States:
  - IDLE: accepts a request if one is pending and no done pulse is asserted this cycle. Acceptance latches addr, len, we and wdata. Next state is READ, or WRITE for stores.
  - READ: issues addresses base+k for k = 0..len-1. The byte issued in cycle c is sampled from mem_din at the end of cycle c+1 into lane k. The state holds one extra cycle to capture the last byte, then returns to IDLE with the done pulse.
  - WRITE: drives mem_a = base+k, mem_dout = wdata lane k, mem_wr = 1 for each byte. Returns to IDLE with the done pulse after the last byte.
- Latency, with acceptance in cycle T:
  - Byte k is issued in cycle T+1+k.
  - Read done pulse is in cycle T+len+2.
  - Write done pulse is in cycle T+len+1.
  - A fetch uses len = FETCH_BYTES.
- Outputs outside READ/WRITE: mem_wr = 0, mem_a = 0, mem_dout = 0.
- Done pulses and data:
  - Exactly one done pulse per accepted request; if_data/ls_rdata change only in that cycle.
  - Load bytes beyond len are 0.
  - No acceptance happens in a done cycle. The requester must drop req in the done cycle or present its next request.
- Arbitration (IDLE, both requesting):
  - ls wins unless starve == STARVE_LIMIT, in which case if wins.
  - starve increments (saturating) when if loses.
  - starve resets to 0 when if is granted.
- io_buffer_full: in WRITE, if addr[17:16] == 2'b11 and io_buffer_full = 1, drive mem_wr = 0 and hold k. Resume on the first cycle io_buffer_full = 0. Any number of stall cycles is allowed.
- IO reads: each IO address is issued exactly once per transaction and is never re-read.
- rdy_in low:
  - All state, counters and outputs freeze; mem_wr is forced to 0 and nothing new is issued.
  - A read byte issued in the cycle before the pause is still captured in the next cycle.
  - Issuing resumes at the same k once rdy_in returns high.
- clear (applied with rdy_in high):
  - A READ in progress (fetch or load) is aborted: IDLE next cycle, no done pulse.
  - A WRITE is never aborted, since committed stores must complete.
  - Requests present in the clear cycle are ignored; starve is reset to 0.
- Address arithmetic is 32-bit; base+k wraps modulo 2^32.

Test Plan:
- Fetch at if_addr=0x100, memory bytes 13 05 00 00, single request accepted at cycle T -> mem_a = 0x100..0x103 in T+1..T+4, if_done in T+6 with if_data = 0x00000513.
- Store ls_len=2 at 0x2000, wdata = 0xDEADBEEF -> writes EF to 0x2000 and BE to 0x2001 with mem_wr=1, ls_done at T+3, no third byte issued.
- Load ls_len=1 from a byte holding 0x80 -> ls_rdata = 0x00000080 (zero-extended), ls_done at T+3.
- Store to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then one write of the byte, done one cycle later.
- ls_req and if_req both held continuously (ls re-requesting after every done) -> if granted after exactly 4 consecutive ls grants.
- clear during a fetch at k=2 -> IDLE next cycle, no if_done; clear during a 4-byte store -> all 4 bytes written and ls_done asserted.
- rdy_in low for 2 cycles mid-load -> mem_a held, mem_wr=0, result identical to the no-pause case, done delayed by 2 cycles.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of requester handshakes and the byte-wide RAM/IO bus owned by mem_bus_arbiter.
// master = the arbiter, slave = requesters plus memory.
interface mem_bus_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [2:0]  ls_len;
  logic [31:0] ls_wdata;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_len, ls_wdata, mem_din, io_buffer_full,
    output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_len, ls_wdata, mem_din, io_buffer_full,
    input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Byte-wide RAM/IO bus arbiter: turns fetch and load/store requests into
// little-endian byte cycles, absorbing the one-cycle RAM read latency.
//
// state | meaning
// IDLE  | bus quiet; arbitrates pending requests when no done pulse is out
// READ  | issues read bytes, then holds one cycle to capture the last byte
// WRITE | drives write bytes; IO addresses stall while the UART buffer is full
module mem_bus_arbiter #(
  parameter int FETCH_BYTES  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  mem_bus_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  localparam int              SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [2:0]      FETCH_LEN  = 3'(FETCH_BYTES);

  logic [1:0]    state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [2:0]    len_q, len_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   buf_q, buf_d;
  logic          fetch_q, fetch_d;
  logic          pend_q, pend_d;
  logic [1:0]    lane_q, lane_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          if_done_q, if_done_d;
  logic          ls_done_q, ls_done_d;
  logic [31:0]   if_data_q, if_data_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;

  logic [31:0] cur_addr;
  logic [31:0] buf_cap;
  logic        io_stall;
  logic        rd_issue;
  logic        grant_ls;
  logic        grant_if;

  assign cur_addr = base_q + {29'd0, k_q};
  assign io_stall = (state_q == ST_WRITE) && (cur_addr[17:16] == 2'b11) && bus.io_buffer_full;
  assign rd_issue = (state_q == ST_READ) && (k_q < len_q);

  assign grant_ls = bus.ls_req && !(bus.if_req && (starve_q == STARVE_MAX));
  assign grant_if = bus.if_req && !grant_ls;

  // A byte issued last cycle lands on mem_din now, whether or not we are paused.
  always_comb begin
    buf_cap = buf_q;
    if (pend_q) begin
      buf_cap[{lane_q, 3'b000} +: 8] = bus.mem_din;
    end
  end

  always_comb begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    if (state_q == ST_WRITE) begin
      bus.mem_a    = cur_addr;
      bus.mem_dout = wdata_q[{k_q[1:0], 3'b000} +: 8];
      bus.mem_wr   = rdy_in && !io_stall;
    end else if (rd_issue) begin
      bus.mem_a = cur_addr;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    len_d      = len_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    fetch_d    = fetch_q;
    lane_d     = lane_q;
    starve_d   = starve_q;
    if_done_d  = if_done_q;
    ls_done_d  = ls_done_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    pend_d     = 1'b0;
    buf_d      = buf_cap;

    if (rdy_in) begin
      if_done_d = 1'b0;
      ls_done_d = 1'b0;
      if (clear) begin
        starve_d = '0;
      end
      case (state_q)
        ST_IDLE: begin
          if (!clear && !if_done_q && !ls_done_q && (bus.if_req || bus.ls_req)) begin
            k_d     = '0;
            buf_d   = '0;
            fetch_d = grant_if;
            wdata_d = bus.ls_wdata;
            if (grant_if) begin
              base_d   = bus.if_addr;
              len_d    = FETCH_LEN;
              state_d  = ST_READ;
              starve_d = '0;
            end else begin
              base_d  = bus.ls_addr;
              len_d   = bus.ls_len;
              state_d = bus.ls_we ? ST_WRITE : ST_READ;
              if (bus.if_req && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + 1'b1;
              end
            end
          end
        end
        ST_READ: begin
          if (clear) begin
            state_d = ST_IDLE;
          end else if (rd_issue) begin
            pend_d = 1'b1;
            lane_d = k_q[1:0];
            k_d    = k_q + 3'd1;
          end else begin
            state_d = ST_IDLE;
            if (fetch_q) begin
              if_data_d = buf_cap;
              if_done_d = 1'b1;
            end else begin
              ls_rdata_d = buf_cap;
              ls_done_d  = 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // Committed stores are never aborted by a flush.
          if (!io_stall) begin
            if (k_q == len_q - 3'd1) begin
              state_d   = ST_IDLE;
              ls_done_d = 1'b1;
            end else begin
              k_d = k_q + 3'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      len_q      <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      fetch_q    <= 1'b0;
      pend_q     <= 1'b0;
      lane_q     <= '0;
      starve_q   <= '0;
      if_done_q  <= 1'b0;
      ls_done_q  <= 1'b0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      len_q      <= len_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      buf_q      <= buf_d;
      fetch_q    <= fetch_d;
      pend_q     <= pend_d;
      lane_q     <= lane_d;
      starve_q   <= starve_d;
      if_done_q  <= if_done_d;
      ls_done_q  <= ls_done_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign bus.if_done  = if_done_q;
  assign bus.ls_done  = ls_done_q;
  assign bus.if_data  = if_data_q;
  assign bus.ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter: a transaction-schedule model predicts every
// output each cycle, with directed scenarios pinning latencies and data literally.
module tb_mem_bus_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst, rdy, clr;
  mem_bus_arbiter_if bus();

  mem_bus_arbiter #(.FETCH_BYTES(4), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear(clr), .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_byte(input int i);
    case (i)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h00;
      32'h103: return 8'h00;
      32'h050: return 8'h80;
      32'h200: return 8'h11;
      32'h201: return 8'h22;
      32'h202: return 8'h33;
      32'h203: return 8'h44;
      default: return 8'((i * 73) ^ (i >> 2) ^ 8'h5A);
    endcase
  endfunction

  // Synchronous RAM/IO: one-cycle read latency, 1 KiB mirrored over the address space.
  logic [7:0] ram [0:1023];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= init_byte(i);
    end else if (bus.mem_wr) begin
      ram[bus.mem_a[9:0]] <= bus.mem_dout;
    end
    bus.mem_din <= ram[bus.mem_a[9:0]];
  end

  // Stimulus for the next cycle, applied at the following falling edge.
  logic        d_rst, d_rdy, d_clr, d_full;
  logic        d_if_req, d_ls_req, d_ls_we;
  logic [31:0] d_if_addr, d_ls_addr, d_ls_wdata;
  logic [2:0]  d_ls_len;

  int  errors = 0, checks = 0, cyc = 0;
  int  wr_cnt = 0, ifd_cnt = 0, lsd_cnt = 0;
  bit  chk_en = 0, seen_ifd = 0, seen_lsd = 0;

  // Reference model: one transaction at a time, tracked by its position in the byte schedule.
  logic [7:0]  mm [0:1023];
  bit          m_busy, m_wr, m_fetch, m_ifd, m_lsd;
  logic [31:0] m_base, m_wdata, m_ifdata, m_lsdata;
  int          m_len, m_pos, m_starve;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] ea;
    logic [7:0]  ed;
    logic        ew;
    ea = '0; ed = '0; ew = 1'b0;
    if (m_busy) begin
      if (m_wr) begin
        ea = m_base + 32'(m_pos);
        ed = 8'(m_wdata >> (8 * m_pos));
        ew = rdy && !((ea[17:16] == 2'b11) && d_full);
      end else if (m_pos < m_len) begin
        ea = m_base + 32'(m_pos);
      end
    end
    chk("mem_a", bus.mem_a, ea);
    chk("mem_dout", 32'(bus.mem_dout), 32'(ed));
    chk("mem_wr", 32'(bus.mem_wr), 32'(ew));
    chk("if_done", 32'(bus.if_done), 32'(m_ifd));
    chk("ls_done", 32'(bus.ls_done), 32'(m_lsd));
    chk("if_data", bus.if_data, m_ifdata);
    chk("ls_rdata", bus.ls_rdata, m_lsdata);
  endtask

  task automatic model_step();
    bit          dn, give_if;
    logic [31:0] a, res;
    if (!rst) begin
      m_busy = 0; m_ifd = 0; m_lsd = 0; m_ifdata = '0; m_lsdata = '0; m_starve = 0;
      for (int i = 0; i < 1024; i++) mm[i] = init_byte(i);
      chk_en = 1;
      return;
    end
    if (!rdy) return;
    dn = m_ifd || m_lsd;
    m_ifd = 0; m_lsd = 0;
    if (clr) m_starve = 0;
    if (m_busy) begin
      if (m_wr) begin
        a = m_base + 32'(m_pos);
        if (!((a[17:16] == 2'b11) && d_full)) begin
          mm[a[9:0]] = 8'(m_wdata >> (8 * m_pos));
          m_pos++;
          if (m_pos == m_len) begin m_busy = 0; m_lsd = 1; end
        end
      end else if (clr) begin
        m_busy = 0;
      end else if (m_pos < m_len) begin
        m_pos++;
      end else begin
        res = '0;
        for (int k = 0; k < m_len; k++) begin
          a = m_base + 32'(k);
          res = res | (32'(mm[a[9:0]]) << (8 * k));
        end
        m_busy = 0;
        if (m_fetch) begin m_ifd = 1; m_ifdata = res; end
        else begin m_lsd = 1; m_lsdata = res; end
      end
    end else if (!clr && !dn && (d_if_req || d_ls_req)) begin
      give_if = d_if_req && (!d_ls_req || m_starve >= STARVE_LIMIT);
      if (give_if) m_starve = 0;
      else if (d_if_req && m_starve < STARVE_LIMIT) m_starve++;
      m_busy  = 1;
      m_pos   = 0;
      m_fetch = give_if;
      m_wr    = !give_if && d_ls_we;
      m_base  = give_if ? d_if_addr : d_ls_addr;
      m_len   = give_if ? 4 : int'(d_ls_len);
      m_wdata = d_ls_wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    rst = d_rst; rdy = d_rdy; clr = d_clr;
    bus.if_req = d_if_req; bus.if_addr = d_if_addr;
    bus.ls_req = d_ls_req; bus.ls_we = d_ls_we; bus.ls_addr = d_ls_addr;
    bus.ls_len = d_ls_len; bus.ls_wdata = d_ls_wdata; bus.io_buffer_full = d_full;
    #1;
    cyc++;
    if (chk_en) check_outputs();
    seen_ifd = bus.if_done;
    seen_lsd = bus.ls_done;
    if (seen_ifd) ifd_cnt++;
    if (seen_lsd) lsd_cnt++;
    if (bus.mem_wr) wr_cnt++;
    model_step();
  endtask

  task automatic run_until(input bit want_if, input int limit, output int n);
    bit hit;
    n = 0;
    hit = 0;
    while (!hit && n < limit) begin
      tick();
      n++;
      hit = want_if ? seen_ifd : seen_lsd;
    end
    chk(want_if ? "if_done_timeout" : "ls_done_timeout", 32'(hit), 32'd1);
  endtask

  task automatic set_ls(input bit we, input logic [31:0] addr, input logic [2:0] len, input logic [31:0] wd);
    d_ls_req = 1; d_ls_we = we; d_ls_addr = addr; d_ls_len = len; d_ls_wdata = wd;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0:       return 32'hFFFF_FFFE;
      1:       return {14'd0, 2'b11, 16'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [2:0] rand_len();
    case ($urandom_range(0, 2))
      0:       return 3'd1;
      1:       return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  int n;

  initial begin
    d_rst = 0; d_rdy = 1; d_clr = 0; d_full = 0;
    d_if_req = 0; d_if_addr = '0; d_ls_req = 0; d_ls_we = 0;
    d_ls_addr = '0; d_ls_len = 3'd1; d_ls_wdata = '0;
    repeat (3) tick();
    d_rst = 1;
    tick();
    chk("rst_mem_a", bus.mem_a, 32'h0);
    chk("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
    chk("rst_if_data", bus.if_data, 32'h0);
    chk("rst_ls_rdata", bus.ls_rdata, 32'h0);

    // Fetch: accept T, bytes T+1..T+4, done T+6.
    d_if_req = 1; d_if_addr = 32'h100;
    run_until(1, 20, n);
    chk("fetch_latency", 32'(n), 32'd7);
    chk("fetch_data", bus.if_data, 32'h0000_0513);
    d_if_req = 0;
    repeat (2) tick();

    // Two-byte store: done T+3, exactly two writes.
    wr_cnt = 0;
    set_ls(1, 32'h2000, 3'd2, 32'hDEAD_BEEF);
    run_until(0, 20, n);
    chk("store_latency", 32'(n), 32'd4);
    chk("store_writes", 32'(wr_cnt), 32'd2);
    chk("store_byte0", 32'(ram[0]), 32'hEF);
    chk("store_byte1", 32'(ram[1]), 32'hBE);
    d_ls_req = 0;
    repeat (2) tick();

    // Single-byte load, zero-extended.
    set_ls(0, 32'h50, 3'd1, 32'h0);
    run_until(0, 20, n);
    chk("load_latency", 32'(n), 32'd4);
    chk("load_data", bus.ls_rdata, 32'h0000_0080);
    d_ls_req = 0;
    repeat (2) tick();

    // IO store held off by a full UART buffer for three cycles.
    wr_cnt = 0; d_full = 1;
    set_ls(1, 32'h0003_0000, 3'd1, 32'h0000_00A5);
    repeat (4) tick();
    chk("io_stall_writes", 32'(wr_cnt), 32'd0);
    d_full = 0;
    run_until(0, 10, n);
    chk("io_resume_latency", 32'(n), 32'd2);
    chk("io_writes", 32'(wr_cnt), 32'd1);
    d_ls_req = 0;
    repeat (2) tick();

    // Four-byte load with a two-cycle pause: done slips from T+6 to T+8.
    set_ls(0, 32'h200, 3'd4, 32'h0);
    repeat (2) tick();
    d_rdy = 0;
    repeat (2) tick();
    d_rdy = 1;
    run_until(0, 20, n);
    chk("pause_latency", 32'(n), 32'd5);
    chk("pause_data", bus.ls_rdata, 32'h4433_2211);
    d_ls_req = 0;
    repeat (2) tick();

    // Starvation: loads re-requested back to back; fetch wins after four of them.
    lsd_cnt = 0; ifd_cnt = 0;
    set_ls(0, 32'h40, 3'd1, 32'h0);
    d_if_req = 1; d_if_addr = 32'h100;
    for (int i = 0; i < 80 && ifd_cnt == 0; i++) tick();
    chk("starve_ls_grants", 32'(lsd_cnt), 32'd4);
    chk("starve_if_grant", 32'(ifd_cnt), 32'd1);
    d_if_req = 0; d_ls_req = 0;
    repeat (2) tick();

    // Flush during a fetch at k=2: back to IDLE, no done.
    d_if_req = 1; d_if_addr = 32'h104;
    repeat (3) tick();
    d_clr = 1;
    tick();
    d_clr = 0; d_if_req = 0; ifd_cnt = 0;
    tick();
    chk("clear_fetch_idle", bus.mem_a, 32'h0);
    repeat (8) tick();
    chk("clear_fetch_nodone", 32'(ifd_cnt), 32'd0);

    // Flush during a four-byte store: all bytes still written.
    wr_cnt = 0;
    set_ls(1, 32'h300, 3'd4, 32'h0BAD_F00D);
    repeat (2) tick();
    d_clr = 1;
    tick();
    d_clr = 0;
    run_until(0, 20, n);
    chk("clear_store_latency", 32'(n), 32'd3);
    chk("clear_store_writes", 32'(wr_cnt), 32'd4);
    d_ls_req = 0;
    repeat (2) tick();

    // Reset mid-fetch: transaction abandoned, no done.
    d_if_req = 1; d_if_addr = 32'h100;
    repeat (3) tick();
    d_rst = 0;
    tick();
    d_rst = 1; d_if_req = 0; ifd_cnt = 0;
    repeat (10) tick();
    chk("reset_nodone", 32'(ifd_cnt), 32'd0);
    chk("reset_if_data", bus.if_data, 32'h0);

    // Random traffic with pauses, flushes and UART back-pressure.
    for (int c = 0; c < 4000; c++) begin
      d_rdy  = ($urandom_range(0, 99) >= 12);
      d_clr  = d_rdy && ($urandom_range(0, 99) < 3);
      d_full = ($urandom_range(0, 99) < 40);
      if (!d_if_req) begin
        if ($urandom_range(0, 2) == 0) begin d_if_req = 1; d_if_addr = rand_addr(); end
      end else if (seen_ifd) begin
        if ($urandom_range(0, 1) == 0) d_if_req = 0;
        else d_if_addr = rand_addr();
      end
      if (!d_ls_req || seen_lsd) begin
        if ($urandom_range(0, 2) == 0)
          set_ls(1'($urandom), rand_addr(), rand_len(), $urandom);
        else
          d_ls_req = 0;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
